mmio_timer: RTL and testbench

Memory-mapped machine timer that responds to the core's data-memory port and drives the core's `ext_int` input. It implements the same request/response contract as the core's `memory` block, so a single upstream address decoder can steer accesses here instead of to RAM. The block holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, a control register and a sticky status register, and raises a level interrupt when `mtime >= mtimecmp`.

---
 rtl/mmio_timer_pkg.sv | 39 +++
 rtl/mmio_timer_if.sv | 29 ++
 rtl/mmio_lane_align.sv | 51 +++++
 rtl/mmio_timer.sv | 175 +++++++++++++++++
 tb/tb_mmio_timer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// ============================================================================
// mmio_timer_pkg : shared constants and encodings for the memory-mapped timer
// Revision       : 1.0
// ============================================================================
`default_nettype none

package mmio_timer_pkg;

    // Byte offsets within the 32-byte window (addr[4:0])
    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_STATUS      = 5'h14;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } op_size_e;

    typedef enum logic [2:0] {
        FAULT_NONE           = 3'd0,
        FAULT_LOAD_MISALIGN  = 3'd4,
        FAULT_LOAD_ACCESS    = 3'd5,
        FAULT_STORE_MISALIGN = 3'd6,
        FAULT_STORE_ACCESS   = 3'd7
    } fault_e;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_IE_BIT      = 1;
    localparam int CTRL_DIV_LSB     = 8;
    localparam int STATUS_MATCH_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/mmio_timer_if.sv
// ============================================================================
// mmio_timer_if : data-memory request/response port plus interrupt level
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface mmio_timer_if;
    logic        enable_n;
    logic        is_write;
    logic        is_unsigned;
    logic [1:0]  op_size;
    logic [31:0] addr;
    logic [31:0] in;
    logic [31:0] out;
    logic [2:0]  fault_num;
    logic        irq;

    modport master (
        output enable_n, is_write, is_unsigned, op_size, addr, in,
        input  out, fault_num, irq
    );

    modport slave (
        input  enable_n, is_write, is_unsigned, op_size, addr, in,
        output out, fault_num, irq
    );
endinterface

`default_nettype wire

// File: rtl/mmio_lane_align.sv
// ============================================================================
// mmio_lane_align : load lane extract/extend and store byte-enable merge
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mmio_lane_align
    import mmio_timer_pkg::*;
(
    input  wire logic [1:0]  op_size,
    input  wire logic [1:0]  lane,
    input  wire logic        is_unsigned,
    input  wire logic [31:0] rd_word,
    input  wire logic [31:0] wr_data,
    output logic      [31:0] ld_data,
    output logic      [31:0] st_merged,
    output logic      [31:0] st_aligned,
    output logic      [3:0]  st_be
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rd_word >> {lane, 3'b000};
        ld_data    = rd_word;
        st_aligned = wr_data;
        st_be      = 4'b1111;
        case (op_size)
            SIZE_BYTE: begin
                ld_data    = is_unsigned ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
                st_aligned = {4{wr_data[7:0]}};
                st_be      = 4'b0001 << lane;
            end
            SIZE_HALF: begin
                ld_data    = is_unsigned ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                st_aligned = {2{wr_data[15:0]}};
                st_be      = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        // Replicated data lets the byte enables alone pick the lanes
        for (int b = 0; b < 4; b++) begin
            st_merged[8*b +: 8] = st_be[b] ? st_aligned[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// mmio_timer : 64-bit machine timer with compare interrupt on the data port
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int PRESCALE_BITS = 8
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    mmio_timer_if.slave   bus
);

    localparam logic [2:0] IDX_MTIME_LO    = OFF_MTIME_LO[4:2];
    localparam logic [2:0] IDX_MTIME_HI    = OFF_MTIME_HI[4:2];
    localparam logic [2:0] IDX_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2];
    localparam logic [2:0] IDX_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2];
    localparam logic [2:0] IDX_CTRL        = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_STATUS      = OFF_STATUS[4:2];

    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic                     ctrl_en_q, ctrl_en_d;
    logic                     ctrl_ie_q, ctrl_ie_d;
    logic [PRESCALE_BITS-1:0] ctrl_div_q, ctrl_div_d;
    logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
    logic                     match_q, match_d;
    logic                     irq_q, irq_d;
    logic [31:0]              out_q, out_d;
    logic [2:0]               fault_q, fault_d;

    logic [2:0]  word_idx;
    logic        access;
    logic [2:0]  fault_code;
    logic [31:0] rd_word;
    logic [31:0] ctrl_word;
    logic [31:0] ld_data;
    logic [31:0] st_merged;
    logic [31:0] st_aligned;
    logic [3:0]  st_be;
    logic        st_ok;
    logic        cmp;
    logic        tick;
    logic        status_clr;
    logic        unused_addr;

    assign word_idx    = bus.addr[4:2];
    assign access      = ~bus.enable_n;
    assign unused_addr = ^bus.addr[31:5];

    always_comb begin
        fault_code = FAULT_NONE;
        if (bus.op_size == SIZE_ILLEGAL) begin
            fault_code = bus.is_write ? FAULT_STORE_ACCESS : FAULT_LOAD_ACCESS;
        end else if ((bus.op_size == SIZE_HALF && bus.addr[0]) ||
                     (bus.op_size == SIZE_WORD && bus.addr[1:0] != 2'b00)) begin
            fault_code = bus.is_write ? FAULT_STORE_MISALIGN : FAULT_LOAD_MISALIGN;
        end else if (word_idx > IDX_STATUS) begin
            fault_code = bus.is_write ? FAULT_STORE_ACCESS : FAULT_LOAD_ACCESS;
        end
    end

    always_comb begin
        ctrl_word                                  = '0;
        ctrl_word[CTRL_EN_BIT]                     = ctrl_en_q;
        ctrl_word[CTRL_IE_BIT]                     = ctrl_ie_q;
        ctrl_word[CTRL_DIV_LSB +: PRESCALE_BITS]   = ctrl_div_q;
    end

    always_comb begin
        rd_word = '0;
        case (word_idx)
            IDX_MTIME_LO:    rd_word = mtime_q[31:0];
            IDX_MTIME_HI:    rd_word = mtime_q[63:32];
            IDX_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
            IDX_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
            IDX_CTRL:        rd_word = ctrl_word;
            IDX_STATUS:      rd_word = {31'd0, match_q};
            default:         rd_word = '0;
        endcase
    end

    mmio_lane_align u_lane_align (
        .op_size     (bus.op_size),
        .lane        (bus.addr[1:0]),
        .is_unsigned (bus.is_unsigned),
        .rd_word     (rd_word),
        .wr_data     (bus.in),
        .ld_data     (ld_data),
        .st_merged   (st_merged),
        .st_aligned  (st_aligned),
        .st_be       (st_be)
    );

    assign st_ok      = access & bus.is_write & (fault_code == FAULT_NONE);
    assign cmp        = (mtime_q >= mtimecmp_q);
    assign tick       = ctrl_en_q & (pcnt_q == ctrl_div_q);
    // Clear only when the store actually covers byte 0 and carries a 1 in bit 0
    assign status_clr = st_ok & (word_idx == IDX_STATUS) & st_be[0] & st_aligned[STATUS_MATCH_BIT];

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_ie_d  = ctrl_ie_q;
        ctrl_div_d = ctrl_div_q;
        pcnt_d     = (!ctrl_en_q || tick) ? '0 : pcnt_q + 1'b1;
        if (st_ok) begin
            case (word_idx)
                IDX_MTIME_LO:    mtime_d             = {mtime_q[63:32], st_merged};
                IDX_MTIME_HI:    mtime_d             = {st_merged, mtime_q[31:0]};
                IDX_MTIMECMP_LO: mtimecmp_d[31:0]    = st_merged;
                IDX_MTIMECMP_HI: mtimecmp_d[63:32]   = st_merged;
                IDX_CTRL: begin
                    ctrl_en_d  = st_merged[CTRL_EN_BIT];
                    ctrl_ie_d  = st_merged[CTRL_IE_BIT];
                    ctrl_div_d = st_merged[CTRL_DIV_LSB +: PRESCALE_BITS];
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end
        match_d = cmp | (match_q & ~status_clr);
        irq_d   = ctrl_ie_q & cmp;
    end

    always_comb begin
        out_d   = out_q;
        fault_d = fault_q;
        if (access) begin
            fault_d = fault_code;
            if (fault_code != FAULT_NONE) begin
                out_d = '0;
            end else if (!bus.is_write) begin
                out_d = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_en_q  <= 1'b0;
            ctrl_ie_q  <= 1'b0;
            ctrl_div_q <= '0;
            pcnt_q     <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
            out_q      <= '0;
            fault_q    <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_ie_q  <= ctrl_ie_d;
            ctrl_div_q <= ctrl_div_d;
            pcnt_q     <= pcnt_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            out_q      <= out_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.fault_num = fault_q;
    assign bus.irq       = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// ============================================================================
// tb_mmio_timer : directed and randomized checks against a behavioural model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_timer;

    localparam int PB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mmio_timer_if bus ();

    mmio_timer #(.PRESCALE_BITS(PB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, held as plain numbers
    longint unsigned m_mtime;
    longint unsigned m_cmp;
    bit              m_en, m_ie, m_match, m_irq;
    int              m_div, m_pcnt;
    bit [31:0]       m_out;
    bit [2:0]        m_fault;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input int idx);
        case (idx)
            0:       return m_mtime[31:0];
            1:       return m_mtime[63:32];
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return (m_div << 8) | (32'(m_ie) << 1) | 32'(m_en);
            5:       return 32'(m_match);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit [2:0] m_fault_of(input bit wr, input bit [1:0] sz, input bit [4:0] a);
        if (sz == 2'd3) return wr ? 3'd7 : 3'd5;
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) return wr ? 3'd6 : 3'd4;
        if (a >= 5'h18) return wr ? 3'd7 : 3'd5;
        return 3'd0;
    endfunction

    function automatic bit [31:0] m_load(input bit [31:0] w, input bit [1:0] lane,
                                         input bit [1:0] sz, input bit uns);
        bit [31:0] v;
        v = w >> (8 * lane);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_step(input bit rst_n, input bit en_n, input bit wr, input bit uns,
                              input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
        bit              cmp_now, tick, clr;
        longint unsigned nt;
        int              np, idx, lane, nb;
        bit [2:0]        f;
        bit [31:0]       w;
        if (!rst_n) begin
            m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_en = 0; m_ie = 0; m_div = 0; m_pcnt = 0;
            m_match = 0; m_irq = 0; m_out = 0; m_fault = 0;
            return;
        end
        cmp_now = (m_mtime >= m_cmp);
        tick    = m_en && (m_pcnt == m_div);
        nt      = tick ? m_mtime + 1 : m_mtime;
        np      = (m_en && !tick) ? m_pcnt + 1 : 0;
        clr     = 0;
        m_irq   = m_ie && cmp_now;
        if (!en_n) begin
            f    = m_fault_of(wr, sz, a[4:0]);
            idx  = int'(a[4:2]);
            lane = int'(a[1:0]);
            m_fault = f;
            if (f != 0) begin
                m_out = 0;
            end else if (!wr) begin
                m_out = m_load(m_read(idx), a[1:0], sz, uns);
            end else begin
                w  = m_read(idx);
                nb = 1 << sz;
                for (int b = 0; b < nb; b++) w[8*(lane+b) +: 8] = d[8*b +: 8];
                case (idx)
                    0: nt = {m_mtime[63:32], w};
                    1: nt = {w, m_mtime[31:0]};
                    2: m_cmp[31:0] = w;
                    3: m_cmp[63:32] = w;
                    4: begin m_en = w[0]; m_ie = w[1]; m_div = int'(w[15:8]); np = 0; end
                    5: clr = (lane == 0) && d[0];
                    default: ;
                endcase
            end
        end
        m_match = cmp_now || (m_match && !clr);
        m_mtime = nt;
        m_pcnt  = np;
    endtask

    task automatic cycle(input bit rst_n, input bit en_n, input bit wr, input bit uns,
                         input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
        reset_n         = rst_n;
        bus.enable_n    = en_n;
        bus.is_write    = wr;
        bus.is_unsigned = uns;
        bus.op_size     = sz;
        bus.addr        = a;
        bus.in          = d;
        model_step(rst_n, en_n, wr, uns, sz, a, d);
        @(posedge clk);
        #1;
        check("out", bus.out, m_out);
        check("fault_num", bus.fault_num, m_fault);
        check("irq", bus.irq, m_irq);
    endtask

    task automatic st(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
        cycle(1, 0, 1, 0, sz, a, d);
    endtask

    task automatic ld(input bit [1:0] sz, input bit uns, input bit [31:0] a);
        cycle(1, 0, 0, uns, sz, a, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 2'd2, 32'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit [31:0] rnd, a, d;
        bit [1:0]  sz;
        int        r;

        cycle(0, 1, 0, 0, 2'd2, 32'd0, 32'd0);
        cycle(0, 1, 0, 0, 2'd2, 32'd0, 32'd0);
        check("rst_out", bus.out, 0);
        check("rst_irq", bus.irq, 0);
        ld(2'd2, 0, 32'h08);
        check("rst_mtimecmp_lo", bus.out, 32'hFFFF_FFFF);
        ld(2'd2, 0, 32'h10);
        check("rst_ctrl", bus.out, 0);

        // Divisor 3: one tick every 4 cycles
        st(2'd2, 32'h10, 32'h0000_0301);
        idle(40);
        ld(2'd2, 0, 32'h00);
        check("div3_mtime", bus.out, 10);

        // Carry from low to high word
        st(2'd2, 32'h10, 32'h0);
        st(2'd2, 32'h04, 32'h0);
        st(2'd2, 32'h00, 32'hFFFF_FFFE);
        st(2'd2, 32'h10, 32'h1);
        idle(2);
        ld(2'd2, 0, 32'h04);
        check("carry_hi", bus.out, 1);
        ld(2'd2, 0, 32'h00);
        check("carry_lo", bus.out, 1);

        // Compare match, sticky status, irq
        st(2'd2, 32'h10, 32'h0);
        st(2'd2, 32'h00, 32'h0);
        st(2'd2, 32'h04, 32'h0);
        st(2'd2, 32'h0C, 32'h0);
        st(2'd2, 32'h08, 32'h5);
        st(2'd2, 32'h10, 32'h3);
        for (int i = 0; i < 30 && bus.irq !== 1'b1; i++) idle(1);
        check("irq_rise", bus.irq, 1);
        ld(2'd2, 0, 32'h14);
        check("status_set", bus.out, 1);
        st(2'd2, 32'h14, 32'h1);
        ld(2'd2, 0, 32'h14);
        check("status_set_wins", bus.out, 1);
        st(2'd2, 32'h0C, 32'hFFFF_FFFF);
        st(2'd2, 32'h08, 32'hFFFF_FFFF);
        st(2'd2, 32'h14, 32'h1);
        ld(2'd2, 0, 32'h14);
        check("status_cleared", bus.out, 0);
        check("irq_cleared", bus.irq, 0);

        // Sign/zero extension of a byte lane
        st(2'd2, 32'h10, 32'h0);
        st(2'd2, 32'h00, 32'h0000_8000);
        ld(2'd0, 0, 32'h01);
        check("byte_signed", bus.out, 32'hFFFF_FF80);
        ld(2'd0, 1, 32'h01);
        check("byte_unsigned", bus.out, 32'h0000_0080);

        // Faults
        ld(2'd2, 0, 32'h02);
        check("fault_ld_misalign", bus.fault_num, 4);
        st(2'd1, 32'h03, 32'h1234);
        check("fault_st_misalign", bus.fault_num, 6);
        ld(2'd2, 0, 32'h00);
        check("fault_no_write", bus.out, 32'h0000_8000);
        ld(2'd2, 0, 32'h18);
        check("fault_ld_access", bus.fault_num, 5);
        st(2'd3, 32'h00, 32'h1);
        check("fault_st_illegal", bus.fault_num, 7);
        ld(2'd2, 0, 32'h00);
        check("fault_cleared", bus.fault_num, 0);

        // Reset mid-count with irq high, cancelling a faulting access
        st(2'd2, 32'h08, 32'h0);
        st(2'd2, 32'h0C, 32'h0);
        st(2'd2, 32'h10, 32'h3);
        idle(3);
        check("pre_reset_irq", bus.irq, 1);
        ld(2'd2, 0, 32'h10);
        cycle(0, 0, 0, 0, 2'd2, 32'h18, 32'h0);
        check("reset_out", bus.out, 0);
        check("reset_fault", bus.fault_num, 0);
        check("reset_irq", bus.irq, 0);
        ld(2'd2, 0, 32'h00);
        check("reset_mtime", bus.out, 0);
        ld(2'd2, 0, 32'h0C);
        check("reset_mtimecmp_hi", bus.out, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                cycle(0, 1, 0, 0, 2'd2, 32'd0, 32'd0);
            end else if (r < 35) begin
                idle(1);
            end else begin
                rnd = $urandom;
                sz  = (rnd[3:0] == 4'd0) ? 2'd3 : 2'(rnd[5:4] % 3);
                a   = $urandom;
                if (rnd[8]) a[4:2] = 3'(rnd[12:10] % 6);
                if (rnd[9]) begin
                    a[1:0] = (sz == 2'd2) ? 2'd0 : (sz == 2'd1) ? {a[1], 1'b0} : a[1:0];
                end
                d = $urandom;
                if (rnd[16]) d = $urandom_range(0, 40);
                if (a[4:2] == 3'd4 && rnd[17]) d = {16'd0, 8'(rnd[20:18]), 6'd0, rnd[22:21]};
                cycle(1, 0, rnd[7], rnd[6], sz, a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
